// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words from a gapped bit stream
// framed by frame_start, with a one-deep output register and a sticky overrun flag.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       frame_start,
  input  logic                       out_ready,
  input  logic                       overrun_clr,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH):0]     bit_cnt,
  output logic                       overrun
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CntFull = CW'(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             ovalid_q, ovalid_d;
  logic             overrun_q, overrun_d;

  logic             continuing;
  logic             accept;
  logic             complete;
  logic             overrun_set;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_inc;

  always_comb begin
    // A frame_start (in either state) restarts from an empty register with count 1.
    continuing = (state_q == SHIFT) && !frame_start;
    accept     = bit_valid && ((state_q == SHIFT) || frame_start);
    base       = continuing ? shift_q : '0;
    cnt_inc    = continuing ? (cnt_q + CW'(1)) : CW'(1);

    if (MSB_FIRST) begin
      shifted = {base[WIDTH-2:0], serial_in};
    end else begin
      shifted = {serial_in, base[WIDTH-1:1]};
    end

    complete    = accept && (cnt_inc == CntFull);
    overrun_set = 1'b0;

    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    pout_d   = pout_q;
    ovalid_d = ovalid_q;

    if (accept) begin
      if (complete) begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_inc;
        shift_d = shifted;
      end
    end

    if (complete) begin
      // A word finishing alongside a handshake replaces the consumed word directly.
      if (!ovalid_q || out_ready) begin
        pout_d   = shifted;
        ovalid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end

    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      pout_q    <= '0;
      ovalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      pout_q    <= pout_d;
      ovalid_q  <= ovalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = pout_q;
  assign out_valid    = ovalid_q;
  assign busy         = (state_q == SHIFT);
  assign bit_cnt      = cnt_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance share all
// inputs; completed words are checked against a queue of expected results.
module tb_sipo_deserializer;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in, bit_valid, frame_start, out_ready, overrun_clr;
  logic [W-1:0]  pout_m, pout_l;
  logic          ovalid_m, ovalid_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .parallel_out(pout_m), .out_valid(ovalid_m), .busy(busy_m), .bit_cnt(cnt_m),
    .overrun(ovr_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
    .parallel_out(pout_l), .out_valid(ovalid_l), .busy(busy_l), .bit_cnt(cnt_l),
    .overrun(ovr_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    serial_in   = b;
    frame_start = fs;
    bit_valid   = 1'b1;
    tick();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Pop the scoreboard and compare it with the MSB-first instance's output word.
  task automatic chk_word(input string tag);
    logic [W-1:0] e;
    chk({tag, "_valid"}, 32'(ovalid_m), 32'd1);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected a word", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_word"}, 32'(pout_m), 32'(e));
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] gw;
    rst = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; overrun_clr = 1'b0;
    #12;
    chk("rst_pout", 32'(pout_m), 32'd0);
    chk("rst_valid", 32'(ovalid_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_cnt", 32'(cnt_m), 32'd0);
    chk("rst_ovr", 32'(ovr_m), 32'd0);
    rst = 1'b1;
    tick();

    // Bits without frame_start in IDLE are ignored
    send_bit(1'b1, 1'b0);
    chk("idle_ign_busy", 32'(busy_m), 32'd0);
    chk("idle_ign_cnt", 32'(cnt_m), 32'd0);

    // Basic reception 1,0,1,1
    send_bit(1'b1, 1'b1);
    chk("basic_busy1", 32'(busy_m), 32'd1);
    chk("basic_cnt1", 32'(cnt_m), 32'd1);
    send_bit(1'b0, 1'b0);
    chk("basic_cnt2", 32'(cnt_m), 32'd2);
    send_bit(1'b1, 1'b0);
    chk("basic_busy3", 32'(busy_m), 32'd1);
    chk("basic_cnt3", 32'(cnt_m), 32'd3);
    exp_q.push_back(4'b1011);
    send_bit(1'b1, 1'b0);
    chk_word("basic");
    chk("basic_busy_end", 32'(busy_m), 32'd0);
    chk("basic_cnt_end", 32'(cnt_m), 32'd0);
    consume();
    chk("hs_valid", 32'(ovalid_m), 32'd0);
    chk("hs_hold", 32'(pout_m), 32'hb);
    consume();
    chk("ready_idle_valid", 32'(ovalid_m), 32'd0);

    // Gapped reception 0,1,1,0 with 3 idle cycles between bits
    gw = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(gw);
      send_bit(gw[3-i], (i == 0));
      if (i < 3) begin
        chk("gap_cnt", 32'(cnt_m), 32'(i + 1));
        for (int g = 0; g < 3; g++) tick();
        chk("gap_hold", 32'(cnt_m), 32'(i + 1));
        chk("gap_busy", 32'(busy_m), 32'd1);
      end
    end
    chk_word("gap");
    consume();

    // Resync: 1,1 then a new frame 0,0,1,0
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("resync_cnt", 32'(cnt_m), 32'd1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    exp_q.push_back(4'b0010);
    send_bit(1'b0, 1'b0);
    chk_word("resync");
    chk("resync_ovr", 32'(ovr_m), 32'd0);
    consume();

    // Overrun: second word dropped while the first is unconsumed
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    exp_q.push_back(4'b1011);
    send_bit(1'b1, 1'b0);
    chk_word("ovr_first");
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("ovr_keep", 32'(pout_m), 32'hb);
    chk("ovr_flag", 32'(ovr_m), 32'd1);
    consume();
    chk("ovr_drain", 32'(ovalid_m), 32'd0);
    chk("ovr_sticky", 32'(ovr_m), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(ovr_m), 32'd0);

    // Completion in the same cycle as a handshake
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    exp_q.push_back(4'b1100);
    send_bit(1'b0, 1'b0);
    chk_word("simA");
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    out_ready = 1'b1;
    exp_q.push_back(4'b0011);
    send_bit(1'b1, 1'b0);
    out_ready = 1'b0;
    chk_word("simB");
    chk("sim_ovr", 32'(ovr_m), 32'd0);

    // Mid-frame asynchronous reset with a word still pending
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("mid_busy", 32'(busy_m), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pout", 32'(pout_m), 32'd0);
    chk("arst_valid", 32'(ovalid_m), 32'd0);
    chk("arst_busy", 32'(busy_m), 32'd0);
    chk("arst_cnt", 32'(cnt_m), 32'd0);
    chk("arst_ovr", 32'(ovr_m), 32'd0);
    chk("arst_lsb_cnt", 32'(cnt_l), 32'd0);
    rst = 1'b1;
    tick();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("post_rst_ign", 32'(busy_m), 32'd0);

    // LSB-first: bits 1,0,0,0 -> 4'b0001 (MSB-first instance sees 4'b1000)
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    exp_q.push_back(4'b1000);
    send_bit(1'b0, 1'b0);
    chk_word("msb_mode");
    chk("lsb_valid", 32'(ovalid_l), 32'd1);
    chk("lsb_word", 32'(pout_l), 32'h1);
    chk("lsb_ovr", 32'(ovr_l), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the word length in bits (legal range 2..32).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1; 1 means the first received bit lands in bit WIDTH-1, 0 means it lands in bit 0.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (asserted at 0).
REQ-005 The module SHALL have port serial_in, input, 1 bit: serial data bit.
REQ-006 The module SHALL have port bit_valid, input, 1 bit: serial_in is sampled on this edge.
REQ-007 The module SHALL have port frame_start, input, 1 bit: when high with bit_valid, marks the first bit of a word.
REQ-008 The module SHALL have port out_ready, input, 1 bit: consumer accepts parallel_out.
REQ-009 The module SHALL have port overrun_clr, input, 1 bit: clears overrun.
REQ-010 The module SHALL have port parallel_out, output, WIDTH bits: last completed word.
REQ-011 The module SHALL have port out_valid, output, 1 bit: parallel_out holds an unconsumed word.
REQ-012 The module SHALL have port busy, output, 1 bit: a frame is partially received.
REQ-013 The module SHALL have port bit_cnt, output, $clog2(WIDTH)+1 bits: bits accepted in the current frame.
REQ-014 The module SHALL have port overrun, output, 1 bit: sticky flag set when a completed word is lost.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and SHIFT; busy SHALL be 1 exactly in SHIFT.
REQ-016 In IDLE, bit_valid=1 with frame_start=0 SHALL be ignored.
REQ-017 In IDLE, bit_valid=1 with frame_start=1 SHALL capture serial_in as bit 1, set bit_cnt=1 and go to SHIFT.
REQ-018 In SHIFT, bit_valid=1 with frame_start=0 SHALL shift serial_in in and increment bit_cnt.
REQ-019 With MSB_FIRST=1 the shift SHALL be shift_reg <= {shift_reg[WIDTH-2:0], serial_in}; with MSB_FIRST=0 it SHALL be shift_reg <= {serial_in, shift_reg[WIDTH-1:1]}.
REQ-020 In SHIFT, bit_valid=0 SHALL hold all state, so gaps between bits are legal and unbounded.
REQ-021 In SHIFT, bit_valid=1 with frame_start=1 SHALL discard the partial word, capture serial_in as bit 1 and set bit_cnt=1 (resync), staying in SHIFT.
REQ-022 Acceptance of the WIDTH-th bit SHALL complete the word: the assembled word including that bit is the result, the FSM goes to IDLE and bit_cnt returns to 0.
REQ-023 On completion, if out_valid=0 or (out_valid=1 and out_ready=1) in the same cycle, parallel_out SHALL load the new word and out_valid SHALL be 1 on the following cycle (latency 1 clock after the last bit's sampling edge).
REQ-024 On completion with out_valid=1 and out_ready=0, the new word SHALL be dropped, parallel_out SHALL be unchanged and overrun SHALL be set.
REQ-025 A handshake (out_valid=1 and out_ready=1) with no completion in the same cycle SHALL clear out_valid; parallel_out SHALL retain its value.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 overrun_clr=1 SHALL clear overrun; if a set condition occurs in the same cycle, set SHALL win.
REQ-028 The module SHALL not stall serial reception; there is no back-pressure on serial_in.

Reset
REQ-029 On rst=0, regardless of clk, the module SHALL immediately set: FSM=IDLE, shift register=0, parallel_out=0, out_valid=0, busy=0, bit_cnt=0, overrun=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial word; the first word after release SHALL require a new frame_start.

Verification (WIDTH=4 unless stated)
REQ-031 A bench SHALL cover basic reception: frame_start on the first bit, bits 1,0,1,1 on consecutive cycles -> parallel_out=4'b1011, with out_valid=1 one cycle after the 4th bit and busy=1 during bits 2-4.
REQ-032 A bench SHALL cover gapped reception: bits 0,1,1,0 with 3 idle cycles between each -> bit_cnt steps 1,2,3 and holds during gaps; parallel_out=4'b0110.
REQ-033 A bench SHALL cover resync: bits 1,1 then frame_start with bits 0,0,1,0 -> parallel_out=4'b0010 and no overrun.
REQ-034 A bench SHALL cover overrun: out_ready=0, word 4'b1011 then word 4'b0101 -> parallel_out stays 4'b1011, overrun=1. Then out_ready=1 -> out_valid=0. Then overrun_clr=1 -> overrun=0.
REQ-035 A bench SHALL cover simultaneous handshake and completion: word B completes in the same cycle out_ready=1 for word A -> parallel_out=B, out_valid stays 1, overrun stays 0.
REQ-036 A bench SHALL cover mid-frame reset and LSB-first mode: rst=0 after 2 bits -> all outputs 0 asynchronously; with MSB_FIRST=0, bits 1,0,0,0 -> parallel_out=4'b0001.
